// File: rtl/system_0_sysid_check_pkg.sv
`default_nettype none
// ============================================================================
// sysid_check_pkg : shared state encoding and error codes for the sysid check
// Rev 1.0
// ============================================================================
package sysid_check_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RD_ID = 2'd1,
        ST_RD_TS = 2'd2,
        ST_CHECK = 2'd3
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ID      = 2'd1;
    localparam logic [1:0] ERR_TS      = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage
`default_nettype wire

// File: rtl/system_0_sysid_check_if.sv
`default_nettype none
// ============================================================================
// system_0_sysid_check_if : Avalon-MM read port between the check and sysid
// Rev 1.0
// ============================================================================
interface system_0_sysid_check_if;

    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata
    );

endinterface
`default_nettype wire

// File: rtl/system_0_sysid_check_wait_timer.sv
`default_nettype none
// ============================================================================
// sysid_wait_timer : stall counter for an Avalon master, expires at LIMIT-1
// Rev 1.0
// ============================================================================
module sysid_wait_timer #(
    parameter int TW    = 11,
    parameter int LIMIT = 1024
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic clr_i,
    input  wire logic en_i,
    output logic      expired_o
);

    localparam logic [TW-1:0] C_LAST = TW'(LIMIT - 1);

    logic [TW-1:0] cnt_q;

    // Saturates at the last value so a late clear never sees a wrapped count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && !expired_o) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired_o = (cnt_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/system_0_sysid_check.sv
`default_nettype none
// ============================================================================
// system_0_sysid_check : reads sysid ID/timestamp after reset, raises id_ok
// Rev 1.0
// ============================================================================
module system_0_sysid_check
    import sysid_check_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'h6098_7FD3,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter int          TW             = 11
) (
    input  wire logic                   clock,
    input  wire logic                   reset_n,
    system_0_sysid_check_if.master      avm,
    input  wire logic                   start,
    output logic                        busy,
    output logic                        done,
    output logic                        id_ok,
    output logic [1:0]                  err_code,
    output logic [31:0]                 id_value,
    output logic [31:0]                 ts_value
);

    state_e      state_q,  state_d;
    logic        arm_q,    arm_d;
    logic        busy_q,   busy_d;
    logic        done_q,   done_d;
    logic        id_ok_q,  id_ok_d;
    logic [1:0]  err_q,    err_d;
    logic [31:0] id_q,     id_d;
    logic [31:0] ts_q,     ts_d;

    logic        w_avm_read;
    logic        w_avm_address;
    logic        w_timer_clr;
    logic        w_timer_en;
    logic        w_expired;

    sysid_wait_timer #(
        .TW    (TW),
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk       (clock),
        .rst_n     (reset_n),
        .clr_i     (w_timer_clr),
        .en_i      (w_timer_en),
        .expired_o (w_expired)
    );

    assign w_timer_en = w_avm_read && avm.avm_waitrequest;

    // The arm flag comes out of reset set, giving the automatic first run.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            arm_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            id_ok_q <= 1'b0;
            err_q   <= ERR_NONE;
            id_q    <= '0;
            ts_q    <= '0;
        end else begin
            state_q <= state_d;
            arm_q   <= arm_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            id_ok_q <= id_ok_d;
            err_q   <= err_d;
            id_q    <= id_d;
            ts_q    <= ts_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        arm_d         = arm_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        id_ok_d       = id_ok_q;
        err_d         = err_q;
        id_d          = id_q;
        ts_d          = ts_q;
        w_avm_read    = 1'b0;
        w_avm_address = 1'b0;
        w_timer_clr   = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (arm_q || start) begin
                    state_d = ST_RD_ID;
                    arm_d   = 1'b0;
                    busy_d  = 1'b1;
                    id_ok_d = 1'b0;
                    err_d   = ERR_NONE;
                end
            end

            ST_RD_ID: begin
                w_avm_read    = 1'b1;
                w_avm_address = 1'b0;
                w_timer_clr   = 1'b0;
                if (!avm.avm_waitrequest) begin
                    id_d        = avm.avm_readdata;
                    state_d     = ST_RD_TS;
                    w_timer_clr = 1'b1;
                end else if (w_expired) begin
                    err_d   = ERR_TIMEOUT;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            ST_RD_TS: begin
                w_avm_read    = 1'b1;
                w_avm_address = 1'b1;
                w_timer_clr   = 1'b0;
                if (!avm.avm_waitrequest) begin
                    ts_d        = avm.avm_readdata;
                    state_d     = ST_CHECK;
                    w_timer_clr = 1'b1;
                end else if (w_expired) begin
                    err_d   = ERR_TIMEOUT;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            ST_CHECK: begin
                // An ID mismatch is reported even when the timestamp is also wrong.
                if (id_q != EXPECTED_ID) begin
                    err_d = ERR_ID;
                end else if (ts_q != EXPECTED_TS) begin
                    err_d = ERR_TS;
                end else begin
                    id_ok_d = 1'b1;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign avm.avm_read    = w_avm_read;
    assign avm.avm_address = w_avm_address;

    assign busy     = busy_q;
    assign done     = done_q;
    assign id_ok    = id_ok_q;
    assign err_code = err_q;
    assign id_value = id_q;
    assign ts_value = ts_q;

endmodule
`default_nettype wire

// File: tb/tb_system_0_sysid_check.sv
`default_nettype none
// ============================================================================
// tb_system_0_sysid_check : directed vector bench for the sysid check master
// Rev 1.0
// ============================================================================
module tb_system_0_sysid_check;

    localparam logic [31:0] C_GOOD_ID = 32'h0000_0000;
    localparam logic [31:0] C_GOOD_TS = 32'd1620606931;
    localparam logic [31:0] C_BAD_TS  = 32'd1620606930;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic        start   = 1'b0;
    logic        wr      = 1'b0;
    logic [31:0] id_word = C_GOOD_ID;
    logic [31:0] ts_word = C_GOOD_TS;

    logic        busy, done, id_ok;
    logic [1:0]  err_code;
    logic [31:0] id_value, ts_value;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    system_0_sysid_check_if bus();

    assign bus.avm_waitrequest = wr;
    assign bus.avm_readdata    = bus.avm_address ? ts_word : id_word;

    system_0_sysid_check #(
        .EXPECTED_ID    (32'h0000_0000),
        .EXPECTED_TS    (32'd1620606931),
        .TIMEOUT_CYCLES (16),
        .TW             (5)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .avm      (bus.master),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .id_ok    (id_ok),
        .err_code (err_code),
        .id_value (id_value),
        .ts_value (ts_value)
    );

    typedef struct {
        logic [31:0] id_w;
        logic [31:0] ts_w;
        int          stall;
        logic [1:0]  err;
        logic        ok;
        int          done_at;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Runs one sequence, acting as a sysid slave that stalls word 0 for v.stall cycles.
    task automatic run_vec(input vec_t v, input bit via_reset, input int idx);
        int  stalls   = 0;
        int  done_cyc = -1;
        int  bus_err  = 0;
        logic exp_rd, exp_ad, exp_busy;
        id_word = v.id_w;
        ts_word = v.ts_w;
        wr      = 1'b0;
        @(negedge clock);
        if (via_reset) begin
            reset_n = 1'b0;
            #2 reset_n = 1'b1;
        end else begin
            start = 1'b1;
        end
        for (int i = 1; i <= 60 && done_cyc < 0; i++) begin
            @(posedge clock);
            #1;
            start = 1'b0;
            exp_busy = (i < v.done_at);
            if (v.err == 2'd3) begin
                exp_rd = (i < v.done_at);
                exp_ad = 1'b0;
            end else begin
                exp_rd = (i <= v.stall + 2);
                exp_ad = (i == v.stall + 2);
            end
            if (bus.avm_read !== exp_rd || (exp_rd && bus.avm_address !== exp_ad) || busy !== exp_busy)
                bus_err++;
            if (done === 1'b1) done_cyc = i;
            wr = bus.avm_read && !bus.avm_address && (stalls < v.stall);
            if (wr) stalls++;
        end
        chk($sformatf("v%0d_bus_seq", idx), bus_err, 0);
        chk($sformatf("v%0d_done_cycle", idx), done_cyc, v.done_at);
        chk($sformatf("v%0d_err_code", idx), err_code, v.err);
        chk($sformatf("v%0d_id_ok", idx), id_ok, v.ok);
        if (v.err != 2'd3) begin
            chk($sformatf("v%0d_id_value", idx), id_value, v.id_w);
            chk($sformatf("v%0d_ts_value", idx), ts_value, v.ts_w);
        end
        wr = 1'b0;
        @(posedge clock);
        #1;
        chk($sformatf("v%0d_done_pulse_width", idx), done, 1'b0);
    endtask

    initial begin
        int cyc;
        int busy_seen;

        tbl[0] = '{C_GOOD_ID,    C_GOOD_TS, 0,  2'd0, 1'b1, 4};
        tbl[1] = '{C_GOOD_ID,    C_BAD_TS,  0,  2'd2, 1'b0, 4};
        tbl[2] = '{32'h1,        C_GOOD_TS, 0,  2'd1, 1'b0, 4};
        tbl[3] = '{32'h1,        C_BAD_TS,  0,  2'd1, 1'b0, 4};
        tbl[4] = '{C_GOOD_ID,    C_GOOD_TS, 5,  2'd0, 1'b1, 9};
        tbl[5] = '{C_GOOD_ID,    C_GOOD_TS, 99, 2'd3, 1'b0, 17};
        tbl[6] = '{C_GOOD_ID,    C_GOOD_TS, 0,  2'd0, 1'b1, 4};

        #1;
        chk("reset_read", bus.avm_read, 1'b0);
        chk("reset_busy_done_ok", {busy, done, id_ok}, 3'b000);
        chk("reset_err", err_code, 2'd0);
        chk("reset_values", id_value | ts_value, 32'h0);

        run_vec(tbl[0], 1'b1, 0);
        for (int k = 1; k < 7; k++) run_vec(tbl[k], 1'b0, k);

        // Results persist while idle.
        repeat (3) @(posedge clock);
        #1;
        chk("hold_id_ok", id_ok, 1'b1);
        chk("hold_busy", busy, 1'b0);

        // start issued in the cycle done is visible is taken from IDLE.
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        chk("coincident_first_done", done, 1'b1);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        chk("coincident_restart_busy", busy, 1'b1);
        chk("coincident_restart_read", {bus.avm_read, bus.avm_address}, 2'b10);
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        chk("coincident_second_done", done, 1'b1);

        // Reset asserted while reading the timestamp.
        id_word = 32'hA5A5_0001;
        ts_word = C_GOOD_TS;
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        @(posedge clock);
        #1;
        chk("midreset_in_rd_ts", {bus.avm_read, bus.avm_address}, 2'b11);
        #2 reset_n = 1'b0;
        #1;
        chk("midreset_read_drop", bus.avm_read, 1'b0);
        chk("midreset_busy_clear", busy, 1'b0);
        chk("midreset_id_cleared", id_value, 32'h0);
        chk("midreset_ts_cleared", ts_value, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        chk("autorun_rd_id", {busy, bus.avm_read, bus.avm_address}, 3'b110);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        cyc = 2;
        while (done !== 1'b1 && cyc < 40) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        chk("autorun_done_cycle", cyc, 4);
        chk("autorun_err", err_code, 2'd1);
        busy_seen = 0;
        repeat (6) begin
            @(posedge clock);
            #1;
            if (busy === 1'b1 || bus.avm_read === 1'b1) busy_seen++;
        end
        chk("start_while_busy_ignored", busy_seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
